// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative write-back data cache with true-LRU
// replacement, a single outstanding miss and a walk-all-entries flush.
module dcache_assoc #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  Dmem2proc_response,
    input  logic [63:0] Dmem2proc_data,
    input  logic [3:0]  Dmem2proc_tag,
    input  logic [31:0] proc2Dcache_addr,
    input  logic [63:0] proc2Dcache_data,
    input  logic [1:0]  proc2Dcache_command,
    input  logic [1:0]  proc2Dcache_size,
    input  logic        flush_req,
    output logic [1:0]  proc2Dmem_command,
    output logic [31:0] proc2Dmem_addr,
    output logic [63:0] proc2Dmem_data,
    output logic [63:0] Dcache_data_out,
    output logic        Dcache_valid_out,
    output logic        finished,
    output logic        flush_done
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = 32 - 3 - IDX_W;
    localparam int FC_W  = IDX_W + WAY_W;

    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [2:0] {IDLE, WB, FETCH, WAIT, FLUSH} state_t;

    state_t state, state_n;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [63:0]         data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

    logic [3:0]       pend_tag;
    logic [WAY_W-1:0] victim_q;
    logic [FC_W-1:0]  fcnt;

    logic [2:0]       req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_act;

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_way;
    logic [63:0]      hit_line, line_sh, ld_data, st_shift, st_line;
    logic [7:0]       size_mask, byte_en;

    logic [IDX_W-1:0] f_set;
    logic [WAY_W-1:0] f_way;
    logic             f_dirty;

    // control strobes from the FSM into the array update
    logic             hit_acc, fill, wb_ack, fetch_ack, fl_adv, fl_wb_ack;
    logic             lru_en;
    logic [WAY_W-1:0] lru_sel;

    assign req_off = proc2Dcache_addr[2:0];
    assign req_idx = proc2Dcache_addr[3 +: IDX_W];
    assign req_tag = proc2Dcache_addr[31 -: TAG_W];
    assign req_act = (proc2Dcache_command == CMD_LOAD) || (proc2Dcache_command == CMD_STORE);

    assign f_set   = fcnt[FC_W-1 -: IDX_W];
    assign f_way   = fcnt[WAY_W-1:0];
    assign f_dirty = valid_q[f_set][f_way] && dirty_q[f_set][f_way];

    // Tag match, lowest invalid way and LRU way for the requested set
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1))
                lru_way = WAY_W'(w);
        end
    end

    assign victim_way = inv_found ? inv_way : lru_way;
    assign hit_line   = data_q[req_idx][hit_way];

    // Load extraction and store byte merge against the hit line
    always_comb begin
        line_sh = hit_line >> {req_off, 3'b000};
        case (proc2Dcache_size)
            2'd0:    begin ld_data = {56'd0, line_sh[7:0]};  size_mask = 8'h01; end
            2'd1:    begin ld_data = {48'd0, line_sh[15:0]}; size_mask = 8'h03; end
            2'd2:    begin ld_data = {32'd0, line_sh[31:0]}; size_mask = 8'h0F; end
            default: begin ld_data = line_sh;                size_mask = 8'hFF; end
        endcase
        byte_en  = size_mask << req_off;
        st_shift = proc2Dcache_data << {req_off, 3'b000};
        st_line  = hit_line;
        for (int b = 0; b < 8; b++)
            if (byte_en[b]) st_line[b*8 +: 8] = st_shift[b*8 +: 8];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state, bus/processor outputs and update strobes; outputs forced low in reset
    always_comb begin
        state_n           = state;
        proc2Dmem_command = 2'd0;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        Dcache_data_out   = '0;
        Dcache_valid_out  = 1'b0;
        finished          = 1'b0;
        flush_done        = 1'b0;
        hit_acc           = 1'b0;
        fill              = 1'b0;
        wb_ack            = 1'b0;
        fetch_ack         = 1'b0;
        fl_adv            = 1'b0;
        fl_wb_ack         = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_n = FLUSH;
                end else if (req_act) begin
                    if (hit) begin
                        finished = 1'b1;
                        hit_acc  = 1'b1;
                        if (proc2Dcache_command == CMD_LOAD) begin
                            Dcache_valid_out = 1'b1;
                            Dcache_data_out  = ld_data;
                        end
                    end else begin
                        // invalid ways are never dirty, so dirty alone picks WB
                        state_n = dirty_q[req_idx][victim_way] ? WB : FETCH;
                    end
                end
            end
            WB: begin
                proc2Dmem_command = CMD_STORE;
                proc2Dmem_addr    = {tag_q[req_idx][victim_q], req_idx, 3'b000};
                proc2Dmem_data    = data_q[req_idx][victim_q];
                if (Dmem2proc_response != 4'd0) begin
                    wb_ack  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                proc2Dmem_command = CMD_LOAD;
                proc2Dmem_addr    = {proc2Dcache_addr[31:3], 3'b000};
                if (Dmem2proc_response != 4'd0) begin
                    fetch_ack = 1'b1;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if ((pend_tag != 4'd0) && (Dmem2proc_tag == pend_tag)) begin
                    fill    = 1'b1;
                    state_n = IDLE;
                end
            end
            FLUSH: begin
                if (f_dirty) begin
                    proc2Dmem_command = CMD_STORE;
                    proc2Dmem_addr    = {tag_q[f_set][f_way], f_set, 3'b000};
                    proc2Dmem_data    = data_q[f_set][f_way];
                    if (Dmem2proc_response != 4'd0) begin
                        fl_wb_ack = 1'b1;
                        fl_adv    = 1'b1;
                    end
                end else begin
                    fl_adv = 1'b1;
                end
                if (fl_adv && (fcnt == '1)) begin
                    flush_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (reset) begin
            proc2Dmem_command = 2'd0;
            proc2Dmem_addr    = '0;
            proc2Dmem_data    = '0;
            Dcache_data_out   = '0;
            Dcache_valid_out  = 1'b0;
            finished          = 1'b0;
            flush_done        = 1'b0;
        end
    end

    assign lru_en  = hit_acc || fill;
    assign lru_sel = fill ? victim_q : hit_way;

    // Cache arrays, LRU ages, pending tag, victim latch and flush walker
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
            pend_tag <= '0;
            victim_q <= '0;
            fcnt     <= '0;
        end else begin
            // the miss is decided in the last IDLE cycle, so latching every IDLE cycle is enough
            if (state == IDLE)
                victim_q <= victim_way;
            if (hit_acc && (proc2Dcache_command == CMD_STORE)) begin
                data_q[req_idx][hit_way]  <= st_line;
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (wb_ack)
                dirty_q[req_idx][victim_q] <= 1'b0;
            if (fetch_ack)
                pend_tag <= Dmem2proc_response;
            if (fill) begin
                data_q[req_idx][victim_q]  <= Dmem2proc_data;
                tag_q[req_idx][victim_q]   <= req_tag;
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                pend_tag                   <= '0;
            end
            if (lru_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == lru_sel)
                        age_q[req_idx][w] <= '0;
                    else if (age_q[req_idx][w] < age_q[req_idx][lru_sel])
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                end
            end
            if (fl_wb_ack)
                dirty_q[f_set][f_way] <= 1'b0;
            if (fl_adv)
                fcnt <= fcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed stimulus with a queue-based scoreboard; a monitor
// pops expected bus requests, command completions and flush pulses in order.
module tb_dcache_assoc;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;
    logic [31:0] proc2Dcache_addr;
    logic [63:0] proc2Dcache_data;
    logic [1:0]  proc2Dcache_command;
    logic [1:0]  proc2Dcache_size;
    logic        flush_req;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [63:0] Dcache_data_out;
    logic        Dcache_valid_out;
    logic        finished;
    logic        flush_done;

    dcache_assoc #(.NUM_SETS(16), .NUM_WAYS(2)) dut (
        .clock(clock), .reset(reset),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_tag(Dmem2proc_tag), .proc2Dcache_addr(proc2Dcache_addr),
        .proc2Dcache_data(proc2Dcache_data), .proc2Dcache_command(proc2Dcache_command),
        .proc2Dcache_size(proc2Dcache_size), .flush_req(flush_req),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data), .Dcache_data_out(Dcache_data_out),
        .Dcache_valid_out(Dcache_valid_out), .finished(finished), .flush_done(flush_done)
    );

    always #5 clock = ~clock;

    typedef enum logic [2:0] {EV_BUS_LD, EV_BUS_ST, EV_LD, EV_ST, EV_FDONE} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t   exp_q[$];
    string exp_nm[$];
    int    checks = 0, errors = 0;
    int    n_bus_st = 0, n_fdone = 0;

    // memory model state
    logic [63:0] mem [logic [31:0]];
    int          stall = 0, ret_delay = 1, ret_cnt = 0;
    logic        ret_busy = 1'b0;
    logic [3:0]  ret_tag = 4'd0, tag_ctr = 4'd1;
    logic [63:0] ret_data = '0;

    // monitor history for detecting the start of a bus request
    logic [1:0]  pcmd = 2'd0;
    logic [31:0] paddr = '0;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {32'hDEAD0000, a};
    endfunction

    task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [63:0] d, input string nm);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
        exp_nm.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [31:0] a, input logic [63:0] d);
        ev_t   e;
        string nm;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected event: got kind=%0d addr=%h data=%h, required none", k, a, d);
        end else begin
            e  = exp_q.pop_front();
            nm = exp_nm.pop_front();
            if (e.kind != k || e.addr != a || e.data != d) begin
                errors++;
                $display("FAIL %s: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         nm, k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Memory: accepts requests after 'stall' refusals, returns load data ret_delay+1 cycles later
    initial begin
        Dmem2proc_response = 4'd0;
        Dmem2proc_tag      = 4'd0;
        Dmem2proc_data     = '0;
        forever begin
            @(negedge clock); #1;
            Dmem2proc_response = 4'd0;
            Dmem2proc_tag      = 4'd0;
            if (ret_busy) begin
                if (ret_cnt == 0) begin
                    Dmem2proc_tag  = ret_tag;
                    Dmem2proc_data = ret_data;
                    ret_busy       = 1'b0;
                end else begin
                    ret_cnt--;
                end
            end
            if (proc2Dmem_command != 2'd0) begin
                if (stall > 0) begin
                    stall--;
                end else begin
                    Dmem2proc_response = tag_ctr;
                    if (proc2Dmem_command == 2'd2) begin
                        mem[proc2Dmem_addr] = proc2Dmem_data;
                    end else begin
                        ret_busy = 1'b1;
                        ret_cnt  = ret_delay;
                        ret_tag  = tag_ctr;
                        ret_data = mem_rd(proc2Dmem_addr);
                    end
                    tag_ctr = (tag_ctr == 4'd15) ? 4'd1 : tag_ctr + 4'd1;
                end
            end
        end
    end

    // Monitor: compare every observable DUT event against the head of the queue
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                pcmd = 2'd0;
            end else begin
                if (proc2Dmem_command != 2'd0 && (proc2Dmem_command != pcmd || proc2Dmem_addr != paddr)) begin
                    if (proc2Dmem_command == 2'd2) begin
                        n_bus_st++;
                        check_ev(EV_BUS_ST, proc2Dmem_addr, proc2Dmem_data);
                    end else begin
                        check_ev(EV_BUS_LD, proc2Dmem_addr, 64'd0);
                    end
                end
                pcmd  = proc2Dmem_command;
                paddr = proc2Dmem_addr;
                if (finished) begin
                    if (Dcache_valid_out) check_ev(EV_LD, 32'd0, Dcache_data_out);
                    else                  check_ev(EV_ST, 32'd0, 64'd0);
                end
                if (flush_done) begin
                    n_fdone++;
                    check_ev(EV_FDONE, 32'd0, 64'd0);
                end
            end
        end
    end

    task automatic do_cmd(input logic [1:0] cmd, input logic [31:0] a, input logic [1:0] sz,
                          input logic [63:0] d, output int lat, output int ld_cyc, output int st_cyc);
        logic done;
        lat = 0; ld_cyc = 0; st_cyc = 0; done = 1'b0;
        @(posedge clock); #1;
        proc2Dcache_command = cmd;
        proc2Dcache_addr    = a;
        proc2Dcache_size    = sz;
        proc2Dcache_data    = d;
        while (!done && lat < 200) begin
            @(negedge clock);
            lat++;
            if (proc2Dmem_command == 2'd1) ld_cyc++;
            if (proc2Dmem_command == 2'd2) st_cyc++;
            done = finished;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL cmd timeout: got no finished for addr %h, required finished within 200 cycles", a);
        end
        @(posedge clock); #1;
        proc2Dcache_command = 2'd0;
    endtask

    task automatic do_flush(input int exp_st);
        int   st0, fd0, cyc;
        logic seen;
        st0 = n_bus_st; fd0 = n_fdone; cyc = 0; seen = 1'b0;
        @(posedge clock); #1;
        flush_req = 1'b1;
        while (!seen && cyc < 400) begin
            @(negedge clock);
            cyc++;
            seen = flush_done;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL flush timeout: got no flush_done, required one within 400 cycles");
        end
        @(posedge clock); #1;
        flush_req = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("flush store count", 64'(n_bus_st - st0), 64'(exp_st));
        chk("flush_done pulses", 64'(n_fdone - fd0), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " mem cmd"},   64'(proc2Dmem_command), 64'd0);
        chk({nm, " mem addr"},  64'(proc2Dmem_addr),    64'd0);
        chk({nm, " mem data"},  proc2Dmem_data,         64'd0);
        chk({nm, " data out"},  Dcache_data_out,        64'd0);
        chk({nm, " valid out"}, 64'(Dcache_valid_out),  64'd0);
        chk({nm, " finished"},  64'(finished),          64'd0);
        chk({nm, " flush_done"},64'(flush_done),        64'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int lat, lc, sc, cyc;
        reset               = 1'b1;
        proc2Dcache_command = 2'd0;
        proc2Dcache_addr    = '0;
        proc2Dcache_data    = '0;
        proc2Dcache_size    = 2'd0;
        flush_req           = 1'b0;
        mem[32'h100] = 64'h1122334455667788;
        mem[32'h180] = 64'hA0A1A2A3A4A5A6A7;
        mem[32'h200] = 64'hB0B1B2B3B4B5B6B7;
        mem[32'h108] = 64'h5555AAAA5555AAAA;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_outputs_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle none finished", 64'(finished), 64'd0);
        chk("idle none bus cmd",  64'(proc2Dmem_command), 64'd0);

        // cold load, then repeat hit
        push(EV_BUS_LD, 32'h100, 64'd0, "cold ld bus");
        push(EV_LD, 32'd0, 64'h11223344, "cold ld data");
        do_cmd(2'd1, 32'h104, 2'd2, 64'd0, lat, lc, sc);
        push(EV_LD, 32'd0, 64'h11223344, "repeat ld data");
        do_cmd(2'd1, 32'h104, 2'd2, 64'd0, lat, lc, sc);
        chk("repeat ld latency", 64'(lat), 64'd1);
        chk("repeat ld bus cycles", 64'(lc + sc), 64'd0);

        // half store merge then double load
        push(EV_ST, 32'd0, 64'd0, "st half");
        do_cmd(2'd2, 32'h102, 2'd1, 64'hBEEF, lat, lc, sc);
        chk("st hit latency", 64'(lat), 64'd1);
        push(EV_LD, 32'd0, 64'h11223344BEEF7788, "ld after st");
        do_cmd(2'd1, 32'h100, 2'd3, 64'd0, lat, lc, sc);

        // fill second way, then evict dirty LRU line 0x100
        push(EV_BUS_LD, 32'h180, 64'd0, "ld 180 bus");
        push(EV_LD, 32'd0, 64'hA0A1A2A3A4A5A6A7, "ld 180 data");
        do_cmd(2'd1, 32'h180, 2'd3, 64'd0, lat, lc, sc);
        push(EV_BUS_ST, 32'h100, 64'h11223344BEEF7788, "evict wb 100");
        push(EV_BUS_LD, 32'h200, 64'd0, "ld 200 bus");
        push(EV_LD, 32'd0, 64'hB0B1B2B3B4B5B6B7, "ld 200 data");
        do_cmd(2'd1, 32'h200, 2'd3, 64'd0, lat, lc, sc);
        chk("evict store cycles", 64'(sc), 64'd1);
        push(EV_LD, 32'd0, 64'hA0A1A2A3A4A5A6A7, "180 retained");
        do_cmd(2'd1, 32'h180, 2'd3, 64'd0, lat, lc, sc);
        chk("180 retained latency", 64'(lat), 64'd1);

        // three dirty lines, then flush
        push(EV_ST, 32'd0, 64'd0, "st byte 200");
        do_cmd(2'd2, 32'h200, 2'd0, 64'h5A, lat, lc, sc);
        push(EV_ST, 32'd0, 64'd0, "st word 184");
        do_cmd(2'd2, 32'h184, 2'd2, 64'hCAFEF00D, lat, lc, sc);
        push(EV_BUS_LD, 32'h108, 64'd0, "st miss 108 bus");
        push(EV_ST, 32'd0, 64'd0, "st dbl 108");
        do_cmd(2'd2, 32'h108, 2'd3, 64'h0123456789ABCDEF, lat, lc, sc);
        push(EV_BUS_ST, 32'h200, 64'hB0B1B2B3B4B5B65A, "flush wb 200");
        push(EV_BUS_ST, 32'h180, 64'hCAFEF00DA4A5A6A7, "flush wb 180");
        push(EV_BUS_ST, 32'h108, 64'h0123456789ABCDEF, "flush wb 108");
        push(EV_FDONE, 32'd0, 64'd0, "flush done");
        do_flush(3);
        push(EV_LD, 32'd0, 64'hB0B1B2B3B4B5B65A, "reload 200");
        do_cmd(2'd1, 32'h200, 2'd3, 64'd0, lat, lc, sc);
        chk("reload 200 latency", 64'(lat), 64'd1);
        push(EV_LD, 32'd0, 64'hCAFEF00DA4A5A6A7, "reload 180");
        do_cmd(2'd1, 32'h180, 2'd3, 64'd0, lat, lc, sc);
        chk("reload 180 latency", 64'(lat), 64'd1);
        push(EV_LD, 32'd0, 64'h0123456789ABCDEF, "reload 108");
        do_cmd(2'd1, 32'h108, 2'd3, 64'd0, lat, lc, sc);
        chk("reload 108 latency", 64'(lat), 64'd1);
        // a second flush proves every dirty bit was cleared
        push(EV_FDONE, 32'd0, 64'd0, "clean flush done");
        do_flush(0);

        // fetch stalled 5 cycles: BUS_LOAD visible 5 stalled cycles plus the accept cycle
        stall = 5;
        push(EV_BUS_LD, 32'h100, 64'd0, "stall ld bus");
        push(EV_LD, 32'd0, 64'h11223344, "stall ld data");
        do_cmd(2'd1, 32'h104, 2'd2, 64'd0, lat, lc, sc);
        chk("stall bus_load cycles", 64'(lc), 64'd6);

        // reset while waiting for the fill; stale tag must be ignored
        ret_delay = 6;
        push(EV_BUS_LD, 32'h300, 64'd0, "pre-reset ld bus");
        @(posedge clock); #1;
        proc2Dcache_command = 2'd1;
        proc2Dcache_addr    = 32'h300;
        proc2Dcache_size    = 2'd3;
        cyc = 0;
        while (proc2Dmem_command != 2'd1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("pre-reset fetch seen", 64'(proc2Dmem_command), 64'd1);
        @(posedge clock); #1;
        reset               = 1'b1;
        proc2Dcache_command = 2'd0;
        @(negedge clock);
        chk_outputs_zero("mid reset");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        ret_delay = 1;
        push(EV_BUS_LD, 32'h300, 64'd0, "post-reset ld 300 bus");
        push(EV_LD, 32'd0, 64'hDEAD000000000300, "post-reset ld 300 data");
        do_cmd(2'd1, 32'h300, 2'd3, 64'd0, lat, lc, sc);
        chk("post-reset 300 missed", 64'(lc > 0), 64'd1);
        push(EV_BUS_LD, 32'h100, 64'd0, "post-reset ld 100 bus");
        push(EV_LD, 32'd0, 64'h11223344, "post-reset ld 100 data");
        do_cmd(2'd1, 32'h104, 2'd2, 64'd0, lat, lc, sc);
        chk("post-reset 100 missed", 64'(lc > 0), 64'd1);

        repeat (5) @(posedge clock);
        #1;
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
